// File: rtl/gray_ctrl_pkg.sv
// rtl/gray_ctrl_pkg.sv - shared types and constants for the Gray burst sequencer
package gray_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int LEN_W_DEF      = 4;

  // Requester indices, also the encoding of the round-robin pointer.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gray_step.sv
// rtl/gray_step.sv - combinational next-Gray-code step, up or down
//
// Ports:
//   gray  in   WIDTH  current Gray code
//   dir   in   1      0 = count up, 1 = count down
//   nxt   out  WIDTH  Gray code one step along the chosen direction
//   last  out  1      gray is the final code before wrapping in that direction
module gray_step
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             last
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;

  // Step in binary and re-encode; binary bit i is the XOR of Gray bits i and up.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
    bin_nxt = dir ? (bin - WIDTH'(1)) : (bin + WIDTH'(1));
    nxt     = bin_nxt ^ (bin_nxt >> 1);
    last    = dir ? (bin == '0) : (bin == '1);
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - two-requester burst arbiter driving a shared Gray counter
//
// Ports:
//   clk     in   1      clock, rising edge
//   reset   in   1      asynchronous active-low reset
//   dir     in   1      count direction, latched in GRANT (only with GRAY_DOWN_EN)
//   req     in   2      per-requester request, held for the whole burst
//   len0    in   LEN_W  burst length in steps for requester 0
//   len1    in   LEN_W  burst length in steps for requester 1
//   gnt     out  2      one-hot grant, 00 when idle
//   busy    out  1      state is not IDLE
//   cnt_en  out  1      a Gray step happens at the next edge
//   gray    out  WIDTH  shared Gray count, kept across bursts
//   done    out  2      one-cycle completion pulse per requester
//   wrap    out  1      one-cycle pulse after the edge where gray wrapped
//
// Build option: define GRAY_DOWN_EN to add the dir port and down counting.
module gray_seq_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
`ifdef GRAY_DOWN_EN
  input  logic             dir,
`endif
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             cnt_en,
  output logic [WIDTH-1:0] gray,
  output logic [1:0]       done,
  output logic             wrap
);

  state_t           state;
  logic             gidx;
  logic             ptr;
  logic [LEN_W-1:0] remaining;
  logic             dir_q;
  logic             dir_in;
  logic             win;
  logic [WIDTH-1:0] gray_nxt;
  logic             gray_last;

`ifdef GRAY_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  // The pointer only decides a tie; a lone requester always wins.
  assign win    = (req == 2'b11) ? ptr : ~req[0];
  assign busy   = (state != S_IDLE);
  assign cnt_en = (state == S_RUN) && req[gidx];

  gray_step #(.WIDTH(WIDTH)) u_step (
    .gray (gray),
    .dir  (dir_q),
    .nxt  (gray_nxt),
    .last (gray_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      gnt       <= 2'b00;
      done      <= 2'b00;
      wrap      <= 1'b0;
      gray      <= '0;
      remaining <= '0;
      ptr       <= REQ0;
      gidx      <= REQ0;
      dir_q     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gidx      <= win;
            gnt       <= win ? 2'b10 : 2'b01;
            remaining <= win ? len1 : len0;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          dir_q <= dir_in;
          if (remaining == '0) begin
            state <= S_DONE;
            done  <= gnt;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (req[gidx]) begin
            gray      <= gray_nxt;
            wrap      <= gray_last;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= S_DONE;
              done  <= gnt;
            end
          end else begin
            // Requester withdrew: abandon the burst silently.
            state <= S_IDLE;
            gnt   <= 2'b00;
            ptr   <= ~gidx;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
          ptr   <= ~gidx;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving the Gray counter width in bits.
REQ-002 SHALL have parameter LEN_W, default 4, giving the burst-length field width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-requester request; level-held for the whole burst.
REQ-006 SHALL have ports len0 and len1  input  LEN_W each  burst length in Gray steps, for requester 0 and requester 1.
REQ-007 SHALL have port gnt  output  2  one-hot grant, or 00 when no requester is granted.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port cnt_en  output  1  high in each cycle where a Gray step occurs at the next edge.
REQ-010 SHALL have port gray  output  WIDTH  the shared registered Gray count.
REQ-011 SHALL have port done  output  2  one-cycle completion pulse, per requester.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse, registered on the edge where gray wraps.

Function
REQ-013 SHALL implement the states IDLE, GRANT, RUN and DONE.
REQ-014 SHALL leave IDLE for GRANT when any req bit is high, setting gnt to the winner.
REQ-015 SHALL latch the winner's len into a remaining counter on entry to GRANT.
REQ-016 SHALL resolve a simultaneous req=11 with a round-robin pointer, which favours requester 0 after reset.
REQ-017 SHALL go from GRANT to RUN when remaining is not 0, and from GRANT directly to DONE when remaining is 0; a zero-length burst produces no step.
REQ-018 SHALL drive cnt_en = (state==RUN) & req[granted] combinationally.
REQ-019 SHALL, on each cnt_en edge, advance gray by one Gray-code step and decrement remaining.
REQ-020 SHALL move RUN to DONE on the edge where remaining goes from 1 to 0.
REQ-021 SHALL follow the up-count sequence for WIDTH=3: 000,001,011,010,110,111,101,100,000.
REQ-022 SHALL pulse wrap on the edge where gray goes from the final code (100) to 000.
REQ-023 SHALL, in DONE, pulse done[granted] for one cycle, keep gnt high, then go to IDLE and switch the pointer to the other requester.
REQ-024 SHALL abort a burst when req[granted] is sampled low in RUN: no step on that edge, go to IDLE, clear gnt, switch the pointer, and issue no done pulse.
REQ-025 SHALL keep gray between bursts; it is never cleared except by reset.
REQ-026 SHALL NOT sample req in GRANT, RUN or DONE; the earliest regrant is one IDLE cycle after DONE.
REQ-027 SHALL hold a burst of length L busy for L+2 cycles (GRANT, then L RUN cycles, then DONE).

Reset
REQ-028 SHALL, while reset=0, immediately force: state IDLE, gnt=00, busy=0, cnt_en=0, done=00, wrap=0, gray=0, remaining=0, pointer=requester 0.
REQ-029 SHALL abort any burst in progress when reset is asserted mid-burst, with no done pulse.
REQ-030 SHALL release reset synchronously; the first arbitration happens at the first edge after reset=1.

Configuration
REQ-031 SHALL support a macro named GRAY_DOWN_EN.
REQ-032 With GRAY_DOWN_EN defined, the block SHALL add port dir  input  1.
REQ-033 With GRAY_DOWN_EN defined, dir SHALL be latched in GRANT; dir=1 steps the sequence in reverse, and wrap then pulses on 000 to 100.
REQ-034 Without GRAY_DOWN_EN, the block SHALL have no dir port and SHALL count up only.

Structure
REQ-035 SHALL put the state enum, the default WIDTH and LEN_W, and the requester-index constants in a package named gray_ctrl_pkg.
REQ-036 SHALL place the next-Gray-code computation (gray in, dir in, next gray out, last-code flag out) in a combinational sub-module named gray_step, instantiated once.

Verification
REQ-037 The bench SHALL cover: req=01, len0=5, gray=000 -> gnt=01, then gray 001,011,010,110,111, then done=01 for one cycle, busy for 7 cycles.
REQ-038 The bench SHALL cover: req=11 after reset, len0=2, len1=3 -> requester 0 first with gray reaching 011, then gnt=10 with gray 010,110,111, then done=10.
REQ-039 The bench SHALL cover: req=01, len0=8 from 000 -> wrap pulse on the 100 to 000 edge, final gray=000; with GRAY_DOWN_EN, dir=1 and len0=1 from 000 -> gray=100 and a wrap pulse.
REQ-040 The bench SHALL cover: req=10, len1=0 -> gnt=10 for 2 cycles, cnt_en never high, done=10, gray unchanged.
REQ-041 The bench SHALL cover: req0 dropped after 2 steps from 000 -> gray holds 011, gnt=00 next cycle, no done pulse, and a pending req1 is granted next.
REQ-042 The bench SHALL cover: reset=0 mid-RUN -> gnt=00, busy=0, gray=000 without waiting for a clock edge.
